// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: grant in IDLE, one EXEC cycle, then hold the response in RESP.
//
// state | meaning
// IDLE  | waiting for a request; the only state in which a grant can be issued
// EXEC  | latched operands drive the ALU; its result is captured at the end of the cycle
// RESP  | response is presented and held until the consumer accepts it
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [2:0]  op_select,
    output logic [7:0]  rdA,
    output logic [7:0]  rdB,
    input  logic [7:0]  alu_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    input  logic        rsp_ready,
    output logic        busy,
    output logic [15:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        id_q;
    logic [2:0]  op_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [7:0]  rsp_data_q;
    logic [15:0] txn_count_q, txn_count_d;
    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic        rsp_hs;

    // With both valid, the requester not granted last wins; a lone requester always wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = !rst && (state_q == IDLE) && grant0;
    assign req1_ready = !rst && (state_q == IDLE) && grant1;
    assign xfer       = req0_ready || req1_ready;

    assign rsp_valid  = !rst && (state_q == RESP);
    assign busy       = !rst && (state_q != IDLE);
    assign rsp_hs     = rsp_valid && rsp_ready;

    assign op_select  = op_q;
    assign rdA        = a_q;
    assign rdB        = b_q;
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign txn_count  = txn_count_q;

    always_comb begin
        state_d     = state_q;
        txn_count_d = txn_count_q;
        case (state_q)
            IDLE: begin
                if (xfer) state_d = EXEC;
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d     = IDLE;
                    txn_count_d = txn_count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= 3'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            rsp_data_q   <= 8'd0;
            txn_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            txn_count_q <= txn_count_d;
            if (xfer) begin
                id_q         <= req1_ready;
                last_grant_q <= req1_ready;
                op_q         <= req1_ready ? req1_op : req0_op;
                a_q          <= req1_ready ? req1_a  : req0_a;
                b_q          <= req1_ready ? req1_b  : req0_b;
            end
            if (state_q == EXEC) rsp_data_q <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model
// (expected winner, expected result, expected response count) with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [2:0]  op_select;
    logic [7:0]  rdA, rdB;
    logic [7:0]  alu_result;
    logic        rsp_valid, rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] txn_count;

    int          tests = 0;
    int          fails = 0;
    logic        m_last;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .op_select  (op_select),
        .rdA        (rdA),
        .rdB        (rdB),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .txn_count  (txn_count)
    );

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:       return a + b;
            3'd1:       return a << b[2:0];
            3'd2, 3'd3: return (a < b) ? a : b;
            3'd4:       return a ^ b;
            3'd5:       return a >> b[2:0];
            3'd6:       return a | b;
            default:    return a & b;
        endcase
    endfunction

    always_comb alu_result = alu_ref(op_select, rdA, rdB);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        m_cnt  = 16'h0000;
    endtask

    // One full operation: grant, EXEC (operands scrambled), RESP held for 'stall' cycles, handshake.
    task automatic txn(input logic v0, input logic v1,
                       input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                       input int stall);
        logic       exp_id;
        logic [2:0] exp_op;
        logic [7:0] exp_a, exp_b, exp_data;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1; rsp_ready = 1'b0;
        req0_op = o0; req0_a = a0; req0_b = b0;
        req1_op = o1; req1_a = a1; req1_b = b1;
        #1;
        if (v0 && v1) exp_id = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else          exp_id = v1;
        exp_op   = exp_id ? o1 : o0;
        exp_a    = exp_id ? a1 : a0;
        exp_b    = exp_id ? b1 : b0;
        exp_data = alu_ref(exp_op, exp_a, exp_b);
        chk("grant_ready0", req0_ready, !exp_id);
        chk("grant_ready1", req1_ready, exp_id);
        m_last = exp_id;
        @(negedge clk);
        req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
        #1;
        chk("exec_busy", busy, 1'b1);
        chk("exec_rsp_valid", rsp_valid, 1'b0);
        chk("exec_readies", {req0_ready, req1_ready}, 2'b00);
        chk("exec_op_select", op_select, exp_op);
        chk("exec_rdA", rdA, exp_a);
        chk("exec_rdB", rdB, exp_b);
        @(negedge clk);
        #1;
        chk("resp_valid", rsp_valid, 1'b1);
        chk("resp_id", rsp_id, exp_id);
        chk("resp_data", rsp_data, exp_data);
        chk("resp_count", txn_count, m_cnt);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_id", rsp_id, exp_id);
            chk("stall_data", rsp_data, exp_data);
            chk("stall_readies", {req0_ready, req1_ready}, 2'b00);
            chk("stall_count", txn_count, m_cnt);
            chk("stall_rdA", rdA, exp_a);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        m_cnt = m_cnt + 16'd1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("done_count", txn_count, m_cnt);
        chk("done_busy", busy, 1'b0);
        chk("done_rsp_valid", rsp_valid, 1'b0);
        chk("done_rdA_held", rdA, exp_a);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'd7; req0_a = 8'hAA; req0_b = 8'h55;
        req1_op = 3'd6; req1_a = 8'h11; req1_b = 8'h22;
        m_last = 1'b1; m_cnt = 16'h0000;

        // Reset values, with requests pending to show readies are held off
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_readies", {req0_ready, req1_ready}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_count", txn_count, 16'h0000);
        chk("rst_outputs", {op_select, rdA, rdB, rsp_data, rsp_id}, 28'h0);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

        // Idle with nothing pending
        @(negedge clk);
        #1;
        chk("idle_readies", {req0_ready, req1_ready}, 2'b00);
        chk("idle_busy", busy, 1'b0);

        // Single add on req0
        txn(1'b1, 1'b0, 3'd0, 8'h05, 8'h03, 3'd0, 8'h00, 8'h00, 0);
        chk("add_result_count", txn_count, 16'd1);

        // Contention after reset: req0 first, then req1, then req0 again
        do_reset();
        txn(1'b1, 1'b1, 3'd4, 8'hF0, 8'h0F, 3'd2, 8'h20, 8'h10, 0);
        txn(1'b1, 1'b1, 3'd4, 8'hF0, 8'h0F, 3'd2, 8'h20, 8'h10, 1);
        txn(1'b1, 1'b1, 3'd6, 8'h0C, 8'h30, 3'd3, 8'h7F, 8'h80, 0);

        // Response back-pressure for 4 cycles
        txn(1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 3'd1, 8'h03, 8'h02, 4);

        // Reset in EXEC discards the operation and restores req0 priority
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 3'd0; req0_a = 8'h10; req0_b = 8'h20;
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0;
        #1;
        chk("rst_exec_busy", busy, 1'b0);
        chk("rst_exec_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_count", txn_count, 16'h0000);
        m_last = 1'b1; m_cnt = 16'h0000;
        txn(1'b1, 1'b1, 3'd5, 8'h80, 8'h03, 3'd7, 8'hFF, 8'h0F, 0);

        // Counter wrap
        @(negedge clk);
        force dut.txn_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.txn_count_q;
        m_cnt = 16'hFFFF;
        #1;
        chk("forced_count", txn_count, 16'hFFFF);
        txn(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 3'd0, 8'h01, 8'h01, 0);
        chk("wrap_count", txn_count, 16'h0000);

        // Randomized operations, mixed contention and back-pressure
        for (int n = 0; n < 40; n++) begin
            logic v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            txn(v0, v1,
                3'($urandom), 8'($urandom), 8'($urandom),
                3'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
